// File: rtl/pcs_pkg.sv
// pcs_pkg: shared PCS TX constants, scrambler types and the word-scramble function.
// Holds the payload/header widths, the scrambler polynomial taps (G(x) = 1 + x^39 + x^58),
// the legal sync header codes and scramble_word(), which is reused by the TX scrambler core.
package pcs_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned HDR_WIDTH  = 2;
    localparam int unsigned SCR_LEN    = 58;
    localparam int unsigned SCR_TAP    = 39;

    localparam logic [HDR_WIDTH-1:0] SYNC_DATA = 2'b01;
    localparam logic [HDR_WIDTH-1:0] SYNC_CTRL = 2'b10;

    localparam logic [SCR_LEN-1:0] SCR_SEED_DEFAULT = 58'h3FF_FFFF_FFFF_FFFF;

    // Result of scrambling one word: next scrambler state and scrambled payload.
    typedef struct packed {
        logic [SCR_LEN-1:0]    sr;
        logic [DATA_WIDTH-1:0] y;
    } scr_result_t;

    // sr[0] is the most recent scrambled bit, so y[i-k] = sr[k-1-i] for any tap k > i.
    // Both taps (39, 58) exceed the word width, so every output bit depends only on
    // the incoming state and never on earlier bits of the same word.
    function automatic scr_result_t scramble_word(
        input logic [SCR_LEN-1:0]    sr,
        input logic [DATA_WIDTH-1:0] d
    );
        scr_result_t           res;
        logic [DATA_WIDTH-1:0] rev;
        res = '0;
        rev = '0;
        for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            res.y[i] = d[i] ^ sr[int'(SCR_TAP) - 1 - i] ^ sr[int'(SCR_LEN) - 1 - i];
            rev[int'(DATA_WIDTH) - 1 - i] = res.y[i];
        end
        // Reverse-shift: older history moves up, y[31] lands at sr[0].
        res.sr = {sr[SCR_LEN-DATA_WIDTH-1:0], rev};
        return res;
    endfunction

endpackage

// File: rtl/pcs_scrambler_core.sv
// pcs_scrambler_core: combinational scrambling of one payload word.
// Ports:
//   i_sr    - current scrambler state (last 58 scrambled bits, sr[0] newest)
//   i_data  - payload word, bit 0 transmitted first
//   o_y_c   - scrambled word
//   o_sr_c  - scrambler state after this word
module pcs_scrambler_core
    import pcs_pkg::*;
(
    input  logic [SCR_LEN-1:0]    i_sr,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_y_c,
    output logic [SCR_LEN-1:0]    o_sr_c
);

    scr_result_t res;

    always_comb begin
        res = scramble_word(i_sr, i_data);
    end

    assign o_y_c  = res.y;
    assign o_sr_c = res.sr;

endmodule

// File: rtl/pcs_tx_scrambler.sv
// pcs_tx_scrambler: self-synchronous 64b/66b payload scrambler ahead of the TX gearbox.
// Scrambles 32-bit payload words (two per block), passes the sync header through
// unscrambled, registers everything with a fixed 1-cycle latency and flags bad headers.
// Optional macro SCRAMBLER_BYPASS_EN adds i_bypass (per-word scrambler bypass, state frozen).
// Ports:
//   i_clk, i_reset      - clock, synchronous active-high reset
//   i_bypass            - (SCRAMBLER_BYPASS_EN only) pass payload unscrambled
//   i_tx_data           - payload word from encoder, first word = payload bits 31:0
//   i_tx_sync_hdr       - block sync header (01 data, 10 control)
//   i_tx_data_valid     - word valid
//   o_tx_trdy           - ready to encoder, combinational copy of i_gearbox_trdy
//   i_gearbox_trdy      - ready from gearbox
//   o_tx_data           - scrambled word to gearbox
//   o_tx_sync_hdr       - header to gearbox
//   o_tx_data_valid     - valid to gearbox
//   o_hdr_err           - sticky header error
module pcs_tx_scrambler #(
    parameter int unsigned                  DATA_WIDTH = pcs_pkg::DATA_WIDTH,
    parameter int unsigned                  HDR_WIDTH  = pcs_pkg::HDR_WIDTH,
    parameter logic [pcs_pkg::SCR_LEN-1:0]  SEED       = pcs_pkg::SCR_SEED_DEFAULT
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
`ifdef SCRAMBLER_BYPASS_EN
    input  logic                  i_bypass,
`endif
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    input  logic [HDR_WIDTH-1:0]  i_tx_sync_hdr,
    input  logic                  i_tx_data_valid,
    output logic                  o_tx_trdy,
    input  logic                  i_gearbox_trdy,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic [HDR_WIDTH-1:0]  o_tx_sync_hdr,
    output logic                  o_tx_data_valid,
    output logic                  o_hdr_err
);

    import pcs_pkg::SCR_LEN;
    import pcs_pkg::SYNC_DATA;
    import pcs_pkg::SYNC_CTRL;

    logic [SCR_LEN-1:0]    sr_q,      sr_d;
    logic                  wi_q,      wi_d;
    logic [HDR_WIDTH-1:0]  hdr_lat_q, hdr_lat_d;
    logic [DATA_WIDTH-1:0] data_q,    data_d;
    logic [HDR_WIDTH-1:0]  hdr_q,     hdr_d;
    logic                  valid_q,   valid_d;
    logic                  err_q,     err_d;

    logic [DATA_WIDTH-1:0] scr_y_c;
    logic [SCR_LEN-1:0]    scr_sr_c;
    logic                  hdr_bad_c;

    // Back-pressure is a straight pass-through; this block never stalls.
    assign o_tx_trdy = i_gearbox_trdy;

    pcs_scrambler_core u_core (
        .i_sr   (sr_q),
        .i_data (i_tx_data),
        .o_y_c  (scr_y_c),
        .o_sr_c (scr_sr_c)
    );

    // Illegal code, or second half of a block disagreeing with the first half.
    assign hdr_bad_c = ((i_tx_sync_hdr != SYNC_DATA) && (i_tx_sync_hdr != SYNC_CTRL)) ||
                       (wi_q && (i_tx_sync_hdr != hdr_lat_q));

    // Next-state: everything freezes on idle cycles except the valid flag.
    always_comb begin
        sr_d      = sr_q;
        wi_d      = wi_q;
        hdr_lat_d = hdr_lat_q;
        data_d    = data_q;
        hdr_d     = hdr_q;
        valid_d   = i_tx_data_valid;
        err_d     = err_q;
        if (i_tx_data_valid) begin
            wi_d  = ~wi_q;
            hdr_d = i_tx_sync_hdr;
            err_d = err_q | hdr_bad_c;
            if (!wi_q) begin
                hdr_lat_d = i_tx_sync_hdr;
            end
`ifdef SCRAMBLER_BYPASS_EN
            data_d = i_bypass ? i_tx_data : scr_y_c;
            sr_d   = i_bypass ? sr_q      : scr_sr_c;
`else
            data_d = scr_y_c;
            sr_d   = scr_sr_c;
`endif
        end
    end

    // State and output registers; reset wins over a coincident valid word.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sr_q      <= SEED;
            wi_q      <= 1'b0;
            hdr_lat_q <= '0;
            data_q    <= '0;
            hdr_q     <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            sr_q      <= sr_d;
            wi_q      <= wi_d;
            hdr_lat_q <= hdr_lat_d;
            data_q    <= data_d;
            hdr_q     <= hdr_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign o_tx_data       = data_q;
    assign o_tx_sync_hdr   = hdr_q;
    assign o_tx_data_valid = valid_q;
    assign o_hdr_err       = err_q;

endmodule

// File: tb/tb_pcs_tx_scrambler.sv
// tb_pcs_tx_scrambler: scoreboard bench for pcs_tx_scrambler.
// Reference model keeps the scrambled bit stream as a plain bit history and applies
// y = d ^ y(-39) ^ y(-58) bit by bit; a monitor pops expected words when the DUT
// presents valid output and also descrambles the DUT output back to the input.
module tb_pcs_tx_scrambler;

    localparam logic [57:0] SEED = 58'h3FF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld;
    logic        gb;
    logic [31:0] din;
    logic [1:0]  hin;
    logic        byp_now;
    logic        trdy;
    logic [31:0] dout;
    logic [1:0]  hout;
    logic        ov;
    logic        err;

    typedef struct {
        logic [31:0] y;
        logic [1:0]  h;
        logic [31:0] d;
        logic        byp;
    } exp_t;

    exp_t        sbq[$];
    bit          tx_hist[$];
    bit          rx_hist[$];
    logic [31:0] last_data;
    logic [1:0]  last_hdr;
    bit          mon_en = 1'b0;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    pcs_tx_scrambler dut (
        .i_clk           (clk),
        .i_reset         (rst),
`ifdef SCRAMBLER_BYPASS_EN
        .i_bypass        (byp_now),
`endif
        .i_tx_data       (din),
        .i_tx_sync_hdr   (hin),
        .i_tx_data_valid (vld),
        .o_tx_trdy       (trdy),
        .i_gearbox_trdy  (gb),
        .o_tx_data       (dout),
        .o_tx_sync_hdr   (hout),
        .o_tx_data_valid (ov),
        .o_hdr_err       (err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Seed history: hist[size-k] is the scrambled bit k positions back = SEED[k-1].
    function automatic void reset_model();
        tx_hist.delete();
        rx_hist.delete();
        for (int k = 57; k >= 0; k--) begin
            tx_hist.push_back(SEED[k]);
            rx_hist.push_back(SEED[k]);
        end
        sbq.delete();
        last_data = '0;
        last_hdr  = '0;
    endfunction

    function automatic logic [31:0] ref_scramble(input logic [31:0] d);
        logic [31:0] y;
        for (int i = 0; i < 32; i++) begin
            y[i] = d[i] ^ tx_hist[tx_hist.size() - 39] ^ tx_hist[tx_hist.size() - 58];
            tx_hist.push_back(y[i]);
            if (tx_hist.size() > 58) void'(tx_hist.pop_front());
        end
        return y;
    endfunction

    function automatic logic [31:0] ref_descramble(input logic [31:0] y);
        logic [31:0] x;
        for (int i = 0; i < 32; i++) begin
            x[i] = y[i] ^ rx_hist[rx_hist.size() - 39] ^ rx_hist[rx_hist.size() - 58];
            rx_hist.push_back(y[i]);
            if (rx_hist.size() > 58) void'(rx_hist.pop_front());
        end
        return x;
    endfunction

    // Monitor: expected valid is exactly "a word was accepted at the last edge".
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            check("valid_latency", 64'(ov), 64'(sbq.size() > 0));
            if (ov && sbq.size() > 0) begin
                e = sbq.pop_front();
                check("data", 64'(dout), 64'(e.y));
                check("hdr", 64'(hout), 64'(e.h));
                if (!e.byp) check("descramble", 64'(ref_descramble(dout)), 64'(e.d));
                last_data = dout;
                last_hdr  = hout;
            end else if (!ov) begin
                check("hold_data", 64'(dout), 64'(last_data));
                check("hold_hdr", 64'(hout), 64'(last_hdr));
            end
        end
    end

    task automatic step();
        exp_t e;
        @(posedge clk);
        if (rst) begin
            reset_model();
        end else if (vld) begin
            e.d   = din;
            e.h   = hin;
            e.byp = byp_now;
            e.y   = byp_now ? din : ref_scramble(din);
            sbq.push_back(e);
        end
        #1;
        check("trdy_pass", 64'(trdy), 64'(gb));
    endtask

    task automatic send(input logic [31:0] d, input logic [1:0] h);
        vld = 1'b1;
        din = d;
        hin = h;
        step();
        vld = 1'b0;
    endtask

    task automatic idle(input int n);
        vld = 1'b0;
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0] bh;
        rst = 1'b1; vld = 1'b0; gb = 1'b1; din = '0; hin = '0; byp_now = 1'b0;
        step();
        rst = 1'b0;
        mon_en = 1'b1;
        check("rst_valid", 64'(ov), 64'd0);
        check("rst_data", 64'(dout), 64'd0);
        check("rst_hdr", 64'(hout), 64'd0);
        check("rst_err", 64'(err), 64'd0);

        // Known-answer: two zero words from the all-ones seed.
        send(32'h0, 2'b01);
        check("kat_w0", 64'(dout), 64'h0000_0000);
        send(32'h0, 2'b01);
        check("kat_w1", 64'(dout), 64'h03FF_FF80);
        check("kat_err", 64'(err), 64'd0);

        // Gearbox trdy drop for one cycle; encoder drops valid on the 6th cycle.
        gb = 1'b0;
        #1;
        check("trdy_low_now", 64'(trdy), 64'd0);
        send($urandom, 2'b10);
        gb = 1'b1;
        for (int i = 0; i < 4; i++) send($urandom, 2'b10);
        idle(1);
        check("valid_gap", 64'(ov), 64'd0);
        send($urandom, 2'b10);
        check("valid_resume", 64'(ov), 64'd1);

        // Random blocks with random idle gaps and random gearbox ready.
        for (int b = 0; b < 1000; b++) begin
            bh = $urandom_range(0, 1) ? 2'b01 : 2'b10;
            for (int w = 0; w < 2; w++) begin
                gb = 1'($urandom_range(0, 1));
                idle($urandom_range(0, 2));
                send($urandom, bh);
            end
        end
        gb = 1'b1;
        check("rand_no_err", 64'(err), 64'd0);

        // Illegal header on a first word, sticky.
        do_reset();
        send($urandom, 2'b11);
        check("err_illegal", 64'(err), 64'd1);
        idle(3);
        check("err_sticky", 64'(err), 64'd1);
        do_reset();
        check("err_cleared", 64'(err), 64'd0);
        send($urandom, 2'b01);
        check("err_first_ok", 64'(err), 64'd0);
        send($urandom, 2'b10);
        check("err_mismatch", 64'(err), 64'd1);

        // Reset after first half, coincident with a valid word that must be dropped.
        do_reset();
        send($urandom, 2'b01);
        rst = 1'b1; vld = 1'b1; din = $urandom; hin = 2'b01;
        step();
        rst = 1'b0; vld = 1'b0;
        check("midrst_valid", 64'(ov), 64'd0);
        check("midrst_data", 64'(dout), 64'd0);
        check("midrst_hdr", 64'(hout), 64'd0);
        check("midrst_err", 64'(err), 64'd0);
        send(32'h0, 2'b01);
        check("midrst_w0", 64'(dout), 64'h0000_0000);
        send(32'h0, 2'b01);
        check("midrst_w1", 64'(dout), 64'h03FF_FF80);
        check("midrst_noerr", 64'(err), 64'd0);

`ifdef SCRAMBLER_BYPASS_EN
        // Bypass passes raw data and freezes the scrambler at the seed.
        do_reset();
        byp_now = 1'b1;
        send(32'hDEAD_BEEF, 2'b01);
        check("byp_raw", 64'(dout), 64'hDEAD_BEEF);
        byp_now = 1'b0;
        send(32'h0, 2'b01);
        check("byp_resume0", 64'(dout), 64'h0000_0000);
        send(32'h0, 2'b01);
        check("byp_resume1", 64'(dout), 64'h03FF_FF80);
`endif

        idle(2);
        check("sb_drained", 64'(sbq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pcs_tx_scrambler.md
Name: pcs_tx_scrambler

Overview:
- Self-synchronous 64b/66b payload scrambler (G(x) = 1 + x^39 + x^58) in the PCS TX path.
- Sits directly upstream of the TX gearbox. Consumes 32-bit encoder output (two words per 66-bit block) plus the 2-bit sync header.
- Scrambles only the payload. Delivers the payload, the unscrambled header and a valid to the gearbox with a fixed 1-cycle latency.
- Passes gearbox back-pressure (trdy) to the encoder/MAC.

Parameters:
- DATA_WIDTH, 32, payload word width; only 32 is supported.
- HDR_WIDTH, 2, sync header width.
- SEED, 58'h3FF_FFFF_FFFF_FFFF, scrambler state loaded on reset.

Ports:
- i_clk  in  1  core clock.
- i_reset  in  1  synchronous reset, active-high.
- i_tx_data  in  32  encoded payload word; first word of a block = payload bits 31:0.
- i_tx_sync_hdr  in  2  block sync header; legal values 2'b01 and 2'b10.
- i_tx_data_valid  in  1  word valid.
- o_tx_trdy  out  1  ready to encoder/MAC.
- i_gearbox_trdy  in  1  trdy from gearbox.
- o_tx_data  out  32  scrambled word, to gearbox i_rx_data.
- o_tx_sync_hdr  out  2  header, to gearbox i_rx_sync_hdr.
- o_tx_data_valid  out  1  to gearbox i_rx_data_valid.
- o_hdr_err  out  1  sticky header error.

Behaviour:
- Decided: one clock, i_clk; reset i_reset is synchronous, active-high.
- o_tx_trdy = i_gearbox_trdy, purely combinational. The block consumes exactly 1 cycle of the gearbox's 6-cycle advance-warning budget and never stalls internally.
- State sr[57:0] holds the last 58 scrambled bits; sr[0] is the most recent.
- Per accepted word, bits i = 0..31, LSB first: y[i] = d[i] ^ y[i-39] ^ y[i-58], where y[-k] = sr[k-1].
  - Implemented fully unrolled in one cycle.
  - After the word, new sr = {sr[25:0], y[31:0]} with y[31] at sr[0] (reverse-shift order; defined in the package).
- sr advances only when i_tx_data_valid = 1. Valid-low (idle) cycles freeze sr and word index.
- Word index wi toggles on each valid word: 0 = first half, 1 = second half.
  - The header is sampled when wi = 0.
  - On wi = 1 the input header must equal the latched header.
- Output register, updated every cycle:
  - o_tx_data_valid <= i_tx_data_valid.
  - When valid: o_tx_data <= y, o_tx_sync_hdr <= i_tx_sync_hdr.
  - When not valid: data and header hold their previous value.
- o_hdr_err is set and stays set until reset when a valid word has:
  - header 2'b00 or 2'b11, or
  - wi = 1 and header ≠ latched header.
- Reset values: o_tx_data = 0, o_tx_sync_hdr = 0, o_tx_data_valid = 0, o_hdr_err = 0. Also sr = SEED, wi = 0, latched header = 0.
- Reset mid-block: the partial block is discarded; the next valid word is treated as a first half.
- Reset and valid in the same cycle: reset wins; the word is dropped.
- SEED = 0 with all-zero input produces all-zero output; this is legal and is not flagged.

Optional Feature:
- Macro SCRAMBLER_BYPASS_EN.
- Defined:
  - Adds port i_bypass (in, 1).
  - When i_bypass = 1, o_tx_data <= i_tx_data unscrambled and sr is frozen.
  - Latency, valid, header checks and wi are unchanged.
  - Changing i_bypass mid-block is allowed; it takes effect per word.
- Undefined: no port; always scrambles.

Decomposition:
- Shared package pcs_pkg (extend the existing gearbox package if present) holds:
  - DATA_WIDTH, HDR_WIDTH, SCR_LEN = 58, SCR_TAP = 39;
  - SYNC_DATA = 2'b01, SYNC_CTRL = 2'b10;
  - a function scramble_word(sr, d) returning {new_sr, y}, so the bench reference model reuses it.
- One sub-module is natural: pcs_scrambler_core, combinational scrambling of one word from sr.
- The top level owns the registers, wi, header check and handshake.

Test Plan:
- Reset (SEED all-ones), then two valid words 32'h0, header 2'b01 -> o_tx_data 32'h0000_0000 then 32'h03FF_FF80, each one cycle after its input. o_hdr_err = 0.
- 1000 random blocks with random valid gaps -> output matches a gapless reference stream word-for-word. A bench descrambler recovers the input exactly. Latency is always 1 cycle.
- i_gearbox_trdy low for 1 cycle -> o_tx_trdy low the same cycle. Encoder drops valid on the 6th cycle -> o_tx_data_valid low exactly 1 cycle later; no data lost.
- Header 2'b11 on a first word -> o_hdr_err = 1 next cycle and stays 1. Header 2'b01 then 2'b10 within one block -> o_hdr_err = 1.
- Reset asserted after the first half of a block -> outputs zero next cycle. The next word is scrambled from SEED as a first half, matching the first scenario's values.
- With SCRAMBLER_BYPASS_EN, i_bypass = 1, data 32'hDEAD_BEEF -> o_tx_data = 32'hDEAD_BEEF. Clearing bypass resumes scrambling from the frozen state.
